ctrl_decoder: RTL and testbench

- Registered instruction-control decoder for the 16-bit WISC-style core.
- Maps the 5-bit opcode plus the 2-bit function extension to all datapath, branch and writeback control signals.
- Sits between instruction fetch/decode and the execute/memory/writeback stages.
- Outputs are registered: one cycle of latency after the inputs are sampled.

---
 rtl/ctrl_pkg.sv | 94 +++++++++
 rtl/ctrl_decode_comb.sv | 113 +++++++++++
 rtl/ctrl_decoder.sv | 65 ++++++
 tb/tb_ctrl_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared ISA constants, control-field encodings and the packed control word
// for the WISC-style instruction-control decoder.
package ctrl_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_RSHFT = 5'b11010;
  localparam logic [4:0] OP_RALU  = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_ANDN = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_ROL  = 3'b100,
    ALU_SLL  = 3'b101,
    ALU_ROR  = 3'b110,
    ALU_SRL  = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    EXT_NONE  = 4'b0000,
    EXT_SEQ   = 4'b0001,
    EXT_SLT   = 4'b0010,
    EXT_SLE   = 4'b0011,
    EXT_SCO   = 4'b0100,
    EXT_BTR   = 4'b0101,
    EXT_PASSB = 4'b0110,
    EXT_SLBI  = 4'b0111
  } alu_ext_e;

  typedef enum logic [1:0] {
    OPB_RT   = 2'b00,
    OPB_IMM5 = 2'b01,
    OPB_IMM8 = 2'b10,
    OPB_ZERO = 2'b11
  } opb_sel_e;

  typedef enum logic [1:0] {
    DST_4_2  = 2'b00,
    DST_7_5  = 2'b01,
    DST_10_8 = 2'b10,
    DST_R7   = 2'b11
  } dst_sel_e;

  typedef struct packed {
    alu_op_e  alu_op;
    alu_ext_e alu_op_ext;
    opb_sel_e sel_alu_opB;
    dst_sel_e sel_reg_dst;
    logic     Cin;
    logic     invA;
    logic     invB;
    logic     sign;
    logic     beqz;
    logic     bnez;
    logic     bltz;
    logic     bgez;
    logic     jump;
    logic     sel_pc_opA;
    logic     sel_pc_opB;
    logic     halt;
    logic     mem_write;
    logic     reg_write;
    logic     sel_wb;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational opcode/function decode into the packed control word.
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] op_ext,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (opcode)
      OP_HALT: cw.halt = 1'b1;
      OP_ADDI, OP_SUBI: begin
        cw.alu_op      = ALU_ADD;
        cw.sel_alu_opB = OPB_IMM5;
        cw.sel_reg_dst = DST_7_5;
        cw.sign        = 1'b1;
        cw.reg_write   = 1'b1;
        cw.invA        = (opcode == OP_SUBI);
        cw.Cin         = (opcode == OP_SUBI);
      end
      OP_XORI, OP_ANDNI: begin
        cw.alu_op      = (opcode == OP_XORI) ? ALU_XOR : ALU_ANDN;
        cw.invB        = (opcode == OP_ANDNI);
        cw.sel_alu_opB = OPB_IMM5;
        cw.sel_reg_dst = DST_7_5;
        cw.reg_write   = 1'b1;
      end
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
        cw.alu_op      = alu_op_e'({1'b1, opcode[1:0]});
        cw.sel_alu_opB = OPB_IMM5;
        cw.sel_reg_dst = DST_7_5;
        cw.reg_write   = 1'b1;
      end
      OP_ST, OP_STU: begin
        cw.sel_alu_opB = OPB_IMM5;
        cw.sign        = 1'b1;
        cw.mem_write   = 1'b1;
        // STU also writes the updated base back to Rs
        cw.reg_write   = (opcode == OP_STU);
        cw.sel_reg_dst = (opcode == OP_STU) ? DST_10_8 : DST_4_2;
      end
      OP_LD: begin
        cw.sel_alu_opB = OPB_IMM5;
        cw.sel_reg_dst = DST_7_5;
        cw.sign        = 1'b1;
        cw.reg_write   = 1'b1;
        cw.sel_wb      = 1'b1;
      end
      OP_SLBI, OP_LBI: begin
        cw.alu_op_ext  = (opcode == OP_SLBI) ? EXT_SLBI : EXT_PASSB;
        cw.sign        = (opcode == OP_LBI);
        cw.sel_alu_opB = OPB_IMM8;
        cw.sel_reg_dst = DST_10_8;
        cw.reg_write   = 1'b1;
      end
      OP_BTR: begin
        cw.alu_op_ext = EXT_BTR;
        cw.reg_write  = 1'b1;
      end
      OP_RALU: begin
        cw.reg_write = 1'b1;
        case (op_ext)
          2'b00:   cw.alu_op = ALU_ADD;
          2'b01: begin
            cw.alu_op = ALU_ADD;
            cw.invA   = 1'b1;
            cw.Cin    = 1'b1;
          end
          2'b10:   cw.alu_op = ALU_XOR;
          default: begin
            cw.alu_op = ALU_ANDN;
            cw.invB   = 1'b1;
          end
        endcase
      end
      OP_RSHFT: begin
        cw.alu_op    = alu_op_e'({1'b1, op_ext});
        cw.reg_write = 1'b1;
      end
      OP_SEQ, OP_SLT, OP_SLE: begin
        cw.alu_op_ext = alu_ext_e'({2'b00, opcode[1:0]} + 4'd1);
        cw.invB       = 1'b1;
        cw.Cin        = 1'b1;
        cw.reg_write  = 1'b1;
      end
      OP_SCO: begin
        cw.alu_op_ext = EXT_SCO;
        cw.reg_write  = 1'b1;
      end
      OP_BEQZ: begin cw.beqz = 1'b1; cw.sign = 1'b1; end
      OP_BNEZ: begin cw.bnez = 1'b1; cw.sign = 1'b1; end
      OP_BLTZ: begin cw.bltz = 1'b1; cw.sign = 1'b1; end
      OP_BGEZ: begin cw.bgez = 1'b1; cw.sign = 1'b1; end
      OP_J, OP_JAL: begin
        cw.jump        = 1'b1;
        cw.sel_pc_opB  = 1'b1;
        cw.reg_write   = (opcode == OP_JAL);
        cw.sel_reg_dst = (opcode == OP_JAL) ? DST_R7 : DST_4_2;
      end
      OP_JR, OP_JALR: begin
        cw.jump        = 1'b1;
        cw.sel_pc_opA  = 1'b1;
        cw.sign        = 1'b1;
        cw.reg_write   = (opcode == OP_JALR);
        cw.sel_reg_dst = (opcode == OP_JALR) ? DST_R7 : DST_4_2;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_decoder.sv
// Registered instruction-control decoder: one cycle from opcode/op_ext to
// control outputs; async reset yields the all-zero NOP word.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [1:0] op_ext,
  output logic [2:0] alu_op,
  output logic [3:0] alu_op_ext,
  output logic [1:0] sel_alu_opB,
  output logic [1:0] sel_reg_dst,
  output logic       Cin,
  output logic       invA,
  output logic       invB,
  output logic       sign,
  output logic       beqz,
  output logic       bnez,
  output logic       bltz,
  output logic       bgez,
  output logic       jump,
  output logic       sel_pc_opA,
  output logic       sel_pc_opB,
  output logic       halt,
  output logic       mem_write,
  output logic       reg_write,
  output logic       sel_wb
);

  ctrl_word_t cw_d;
  ctrl_word_t cw_q;

  ctrl_decode_comb u_decode (
    .opcode (opcode),
    .op_ext (op_ext),
    .cw     (cw_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cw_q <= '0;
    else        cw_q <= cw_d;
  end

  assign alu_op      = cw_q.alu_op;
  assign alu_op_ext  = cw_q.alu_op_ext;
  assign sel_alu_opB = cw_q.sel_alu_opB;
  assign sel_reg_dst = cw_q.sel_reg_dst;
  assign Cin         = cw_q.Cin;
  assign invA        = cw_q.invA;
  assign invB        = cw_q.invB;
  assign sign        = cw_q.sign;
  assign beqz        = cw_q.beqz;
  assign bnez        = cw_q.bnez;
  assign bltz        = cw_q.bltz;
  assign bgez        = cw_q.bgez;
  assign jump        = cw_q.jump;
  assign sel_pc_opA  = cw_q.sel_pc_opA;
  assign sel_pc_opB  = cw_q.sel_pc_opB;
  assign halt        = cw_q.halt;
  assign mem_write   = cw_q.mem_write;
  assign reg_write   = cw_q.reg_write;
  assign sel_wb      = cw_q.sel_wb;

endmodule

// File: tb/tb_ctrl_decoder.sv
// Self-checking bench for ctrl_decoder: directed cases plus random opcodes
// compared against a per-signal reference table.
module tb_ctrl_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] opcode = '0;
  logic [1:0] op_ext = '0;
  logic [2:0] alu_op;
  logic [3:0] alu_op_ext;
  logic [1:0] sel_alu_opB, sel_reg_dst;
  logic Cin, invA, invB, sign, beqz, bnez, bltz, bgez, jump;
  logic sel_pc_opA, sel_pc_opB, halt, mem_write, reg_write, sel_wb;

  int checks = 0;
  int failures = 0;
  logic [25:0] prev_exp = '0;

  always #5 clk = ~clk;

  ctrl_decoder dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .op_ext(op_ext),
    .alu_op(alu_op), .alu_op_ext(alu_op_ext), .sel_alu_opB(sel_alu_opB),
    .sel_reg_dst(sel_reg_dst), .Cin(Cin), .invA(invA), .invB(invB),
    .sign(sign), .beqz(beqz), .bnez(bnez), .bltz(bltz), .bgez(bgez),
    .jump(jump), .sel_pc_opA(sel_pc_opA), .sel_pc_opB(sel_pc_opB),
    .halt(halt), .mem_write(mem_write), .reg_write(reg_write), .sel_wb(sel_wb)
  );

  wire [25:0] obs = {alu_op, alu_op_ext, sel_alu_opB, sel_reg_dst, Cin, invA,
                     invB, sign, beqz, bnez, bltz, bgez, jump, sel_pc_opA,
                     sel_pc_opB, halt, mem_write, reg_write, sel_wb};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (op=%b ext=%b t=%0t)",
               tag, got, exp, opcode, op_ext, $time);
    end
  endtask

  // Each output is stated as the set of instructions that drive it.
  function automatic logic [25:0] ref_decode(input logic [4:0] o5,
                                             input logic [1:0] e2);
    int o = int'(o5);
    int e = int'(e2);
    logic [2:0] a = '0;
    logic [3:0] x = '0;
    logic [1:0] b = '0, d = '0;
    logic c, ia, ib, sg, bq, bn, bl, bg, jp, pa, pb, h, mw, rw, wb;
    h  = (o == 0);
    mw = (o == 16 || o == 19);
    wb = (o == 17);
    jp = (o >= 4 && o <= 7);
    pa = (o == 5 || o == 7);
    pb = (o == 4 || o == 6);
    bq = (o == 12); bn = (o == 13); bl = (o == 14); bg = (o == 15);
    sg = (o == 8 || o == 9 || o == 16 || o == 17 || o == 19 || o == 24 ||
          (o >= 12 && o <= 15) || o == 5 || o == 7);
    rw = ((o >= 8 && o <= 11) || (o >= 20 && o <= 31) || o == 17 ||
          o == 18 || o == 19 || o == 6 || o == 7);
    ia = (o == 9) || (o == 27 && e == 1);
    c  = ia || (o >= 28 && o <= 30);
    ib = (o == 11) || (o == 27 && e == 3) || (o >= 28 && o <= 30);
    if ((o >= 8 && o <= 11) || (o >= 20 && o <= 23) || o == 16 || o == 17 || o == 19)
      b = 2'd1;
    else if (o == 18 || o == 24) b = 2'd2;
    if ((o >= 8 && o <= 11) || (o >= 20 && o <= 23) || o == 17) d = 2'd1;
    else if (o == 18 || o == 19 || o == 24) d = 2'd2;
    else if (o == 6 || o == 7) d = 2'd3;
    if (o >= 20 && o <= 23) a = 3'(4 + (o % 4));
    else if (o == 26) a = 3'(4 + e);
    else if (o == 10 || (o == 27 && e == 2)) a = 3'd2;
    else if (o == 11 || (o == 27 && e == 3)) a = 3'd1;
    case (o)
      18: x = 4'd7;
      24: x = 4'd6;
      25: x = 4'd5;
      28: x = 4'd1;
      29: x = 4'd2;
      30: x = 4'd3;
      31: x = 4'd4;
      default: x = 4'd0;
    endcase
    return {a, x, b, d, c, ia, ib, sg, bq, bn, bl, bg, jp, pa, pb, h, mw, rw, wb};
  endfunction

  // Called 1 time unit after a rising edge; checks that outputs hold until
  // the next edge and then carry the new decode.
  task automatic step(input logic [4:0] o, input logic [1:0] e);
    logic [25:0] exp;
    opcode = o;
    op_ext = e;
    exp = ref_decode(o, e);
    #2;
    check_eq("hold_before_edge", 32'(obs), 32'(prev_exp));
    @(posedge clk);
    #1;
    check_eq("decode", 32'(obs), 32'(exp));
    check_eq("one_branch", 32'($countones({beqz, bnez, bltz, bgez}) <= 1), 32'd1);
    check_eq("halt_vs_store", 32'(halt & mem_write), 32'd0);
    prev_exp = exp;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    opcode = 5'b11111;
    op_ext = 2'b11;
    #1;
    check_eq("reset_no_edge", 32'(obs), 32'd0);
    @(posedge clk); #1;
    check_eq("reset_held", 32'(obs), 32'd0);
    rst_n = 1'b1;

    step(5'b00000, 2'b00);
    check_eq("halt_bit", 32'(halt), 32'd1);
    step(5'b11111, 2'b11);
    check_eq("sco_ext", 32'(alu_op_ext), 32'h4);
    check_eq("sco_rw", 32'({reg_write, halt, mem_write, jump}), 32'b1000);
    step(5'b10101, 2'b01);
    check_eq("slli_alu", 32'({alu_op, sel_alu_opB, sel_reg_dst}), 32'b101_01_01);
    for (int i = 0; i < 4; i++) begin
      step(5'b11011, 2'(i));
      check_eq("ralu_alu", 32'({alu_op, invA, Cin, invB}),
               (i == 0) ? 32'b000_000 : (i == 1) ? 32'b000_110 :
               (i == 2) ? 32'b010_000 : 32'b001_001);
    end
    for (int i = 12; i < 16; i++) begin
      step(5'(i), 2'(i));
      check_eq("branch_onehot", 32'({beqz, bnez, bltz, bgez, reg_write}),
               32'(5'b10000 >> (i - 12)));
    end
    step(5'b00110, 2'b00);
    check_eq("jal", 32'({jump, reg_write, sel_reg_dst, sel_pc_opB}), 32'b11111);

    for (int i = 0; i < 4; i++) step(5'b10001, 2'b10);
    step(5'b00111, 2'b01);

    for (int n = 0; n < 200; n++) begin
      logic [4:0] o;
      logic [1:0] e;
      o = 5'($urandom_range(0, 31));
      e = 2'($urandom_range(0, 3));
      step(o, e);
      if ($urandom_range(0, 3) == 0) step(o, e);
    end

    step(5'b01000, 2'b00);
    rst_n = 1'b0;
    #1;
    check_eq("midstream_reset", 32'(obs), 32'd0);
    @(posedge clk); #1;
    check_eq("reset_hold_edge", 32'(obs), 32'd0);
    rst_n = 1'b1;
    prev_exp = '0;
    step(5'b10011, 2'b00);
    step(5'b11000, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
